// File: rtl/divider_16_bit.sv
// Iterative restoring unsigned divider: one quotient bit per clock by trial subtraction.
// Results and the divide-by-zero flag are registered on entry to DONE and held until the next accepted start.
module divider_16_bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH:0]   r_reg, r_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  // One restoring step: shift the next dividend bit into R and trial-subtract D.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    rem_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, d_reg};
    // R stays below D, so R[WIDTH] is always clear; a set bit would still mean the subtraction fits.
    fits      = ~trial[WIDTH] | r_reg[WIDTH];
    r_step    = fits ? trial : rem_shift;
    q_step    = {q_reg[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      d_reg         <= d_next;
      r_reg         <= r_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    d_next         = d_reg;
    r_next         = r_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          q_next     = dividend;
          d_next     = divisor;
          r_next     = '0;
          count_next = '0;
          dbz_next   = 1'b0;
          if (divisor == '0) begin
            // Zero divisor skips the iteration and publishes the fixed result immediately.
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        q_next     = q_step;
        r_next     = r_step;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST_STEP) begin
          state_next     = DONE;
          quotient_next  = q_step;
          remainder_next = r_step[WIDTH-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_16_bit.sv
// Directed and randomized checks of divider_16_bit against a plain-arithmetic reference model.
module tb_divider_16_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [15:0] prev_q = 16'h0;
  logic [15:0] prev_r = 16'h0;

  divider_16_bit #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    if (b == 16'h0) begin
      q = 16'hFFFF;
      r = a;
      dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      dz = 1'b0;
    end
  endtask

  // Entered at a falling edge after the accepting edge; c0 is the cycle count already elapsed.
  task automatic wait_done(input int c0, output int cycles, output int busy_cnt, output int unstable);
    cycles = c0;
    busy_cnt = 0;
    unstable = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (quotient !== prev_q || remainder !== prev_r) unstable++;
      @(negedge clk);
      cycles++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eq, er;
    logic edz;
    model(a, b, eq, er, edz);
    check({tag, "_quotient"}, {16'b0, quotient}, {16'b0, eq});
    check({tag, "_remainder"}, {16'b0, remainder}, {16'b0, er});
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edz});
    $display("%s: %h / %h -> q=%h r=%h dbz=%b", tag, a, b, quotient, remainder, div_by_zero);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int cyc, bcnt, unst;
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
    wait_done(1, cyc, bcnt, unst);
    check({tag, "_latency"}, cyc, (b == 16'h0) ? 32'd1 : 32'd17);
    check({tag, "_busy_cycles"}, bcnt, (b == 16'h0) ? 32'd0 : 32'd16);
    check({tag, "_outputs_stable"}, unst, 32'd0);
    check_result(tag, a, b);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int cyc, bcnt, unst, dcount;
    logic [15:0] ra, rb;

    rst = 1'b1;
    start = 1'b0;
    dividend = 16'h0;
    divisor = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_quotient", {16'b0, quotient}, 32'd0);
    check("reset_remainder", {16'b0, remainder}, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;

    run_op("basic", 16'h0064, 16'h0007);
    run_op("ffff_div_1", 16'hFFFF, 16'h0001);
    run_op("8000_div_ffff", 16'h8000, 16'hFFFF);
    run_op("ffff_div_ffff", 16'hFFFF, 16'hFFFF);
    run_op("small_num", 16'h0005, 16'h0009);
    run_op("zero_num", 16'h0000, 16'h0003);
    run_op("div_zero", 16'h1234, 16'h0000);
    run_op("after_dbz", 16'h0100, 16'h0010);

    // A second start during RUN must be ignored.
    @(negedge clk);
    dividend = 16'h00C8;
    divisor = 16'h000A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'h0009;
    divisor = 16'h0003;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, cyc, bcnt, unst);
    check("start_in_run_latency", cyc, 32'd17);
    check_result("start_in_run", 16'h00C8, 16'h000A);
    @(negedge clk);

    // Start held high through DONE re-issues immediately.
    dividend = 16'd1000;
    divisor = 16'd7;
    start = 1'b1;
    @(negedge clk);
    wait_done(1, cyc, bcnt, unst);
    check("b2b_first_latency", cyc, 32'd17);
    check_result("b2b_first", 16'd1000, 16'd7);
    dividend = 16'd50000;
    divisor = 16'd123;
    @(negedge clk);
    start = 1'b0;
    check("b2b_reissued_busy", {31'b0, busy}, 32'd1);
    wait_done(1, cyc, bcnt, unst);
    check("b2b_done_spacing", cyc, 32'd17);
    check_result("b2b_second", 16'd50000, 16'd123);
    @(negedge clk);

    // Reset in the middle of RUN aborts with no done.
    dividend = 16'h0064;
    divisor = 16'h0007;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quotient", {16'b0, quotient}, 32'd0);
    check("midrst_remainder", {16'b0, remainder}, 32'd0);
    prev_q = 16'h0;
    prev_r = 16'h0;
    dcount = 0;
    repeat (20) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("midrst_no_done", dcount, 32'd0);
    run_op("after_midrst", 16'h0064, 16'h0007);

    // Reset beats a simultaneous start.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    dividend = 16'h0005;
    divisor = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_vs_start_done", {31'b0, done}, 32'd0);
    check("rst_vs_start_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_vs_start_quotient", {16'b0, quotient}, 32'd0);
    prev_q = 16'h0;
    prev_r = 16'h0;

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = 16'($urandom_range(1, 15));
        2: rb = (i % 6 == 0) ? 16'h0 : 16'($urandom_range(1, 255));
        default: rb = ra + 16'($urandom_range(1, 100));
      endcase
      run_op("random", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
